// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and default data width for muldiv_alu.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned OP_W          = 6;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_SLL   = 6'b000000;
  localparam opcode_t OP_SRL   = 6'b000010;
  localparam opcode_t OP_SRA   = 6'b000011;
  localparam opcode_t OP_SLLV  = 6'b000100;
  localparam opcode_t OP_SRLV  = 6'b000110;
  localparam opcode_t OP_JR    = 6'b001000;
  localparam opcode_t OP_MFHI  = 6'b010000;
  localparam opcode_t OP_MFLO  = 6'b010010;
  localparam opcode_t OP_MULT  = 6'b011000;
  localparam opcode_t OP_MULTU = 6'b011001;
  localparam opcode_t OP_DIV   = 6'b011010;
  localparam opcode_t OP_DIVU  = 6'b011011;
  localparam opcode_t OP_ADD   = 6'b100000;
  localparam opcode_t OP_ADDU  = 6'b100001;
  localparam opcode_t OP_SUB   = 6'b100010;
  localparam opcode_t OP_SUBU  = 6'b100011;
  localparam opcode_t OP_AND   = 6'b100100;
  localparam opcode_t OP_OR    = 6'b100101;
  localparam opcode_t OP_XOR   = 6'b100110;
  localparam opcode_t OP_SLT   = 6'b101010;
  localparam opcode_t OP_SLTU  = 6'b101011;
  localparam opcode_t OP_BEQ   = 6'b110000;
  localparam opcode_t OP_BNE   = 6'b110001;
  localparam opcode_t OP_BGTZ  = 6'b110010;
  localparam opcode_t OP_BLEZ  = 6'b110011;
  localparam opcode_t OP_BGEZ  = 6'b110100;
  localparam opcode_t OP_BLTZ  = 6'b110101;
  localparam opcode_t OP_LUI   = 6'b111000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative WIDTH-step shift-add multiplier / restoring divider.
// Signed operands are handled as magnitudes with a sign fix-up on the final step.
// Divider datapath present only when MULDIV_ALU_DIV_EN is defined.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opb_q, opb_d;
  logic             neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] abs_a, abs_b, step_acc, step_quo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;

  assign abs_a   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign mul_sum = {1'b0, acc_q} + {1'b0, (quo_q[0] ? opb_q : '0)};
  assign done    = active_q && (cnt_q == LAST);

`ifdef MULDIV_ALU_DIV_EN
  logic             div_q, div_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;

  assign div_shift = {acc_q, quo_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
  assign div_ok    = ~div_diff[WIDTH+1];
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  // One iteration step plus sign fix-up of the would-be final result
  always_comb begin
    step_acc = mul_sum[WIDTH:1];
    step_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
`ifdef MULDIV_ALU_DIV_EN
    if (div_q) begin
      step_acc = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], div_ok};
    end
`endif
    prod = {step_acc, step_quo};
    if (neg_lo_q) prod = -prod;
    hi = prod[2*WIDTH-1:WIDTH];
    lo = prod[WIDTH-1:0];
`ifdef MULDIV_ALU_DIV_EN
    if (div_q) begin
      lo = neg_lo_q ? -step_quo : step_quo;
      hi = neg_hi_q ? -step_acc : step_acc;
    end
`endif
  end

  // Operand load on start, then one step per cycle for WIDTH cycles
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
`ifdef MULDIV_ALU_DIV_EN
    div_d    = div_q;
    neg_hi_d = neg_hi_q;
`endif
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      quo_d    = abs_a;
      opb_d    = abs_b;
      neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_ALU_DIV_EN
      div_d    = is_div;
      neg_hi_d = is_signed && a[WIDTH-1];
      // Zero divisor: raw dividend yields quotient all-ones, remainder = dividend
      if (is_div && (b == '0)) begin
        quo_d    = a;
        neg_lo_d = 1'b0;
        neg_hi_d = 1'b0;
      end
`endif
    end else if (active_q) begin
      acc_d = step_acc;
      quo_d = step_quo;
      cnt_d = cnt_q + CW'(1);
      if (done) active_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
`ifdef MULDIV_ALU_DIV_EN
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
`ifdef MULDIV_ALU_DIV_EN
      div_q    <= div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

endmodule

// File: rtl/muldiv_alu.sv
// MIPS-style ALU: single-cycle ops plus iterative MULT/MULTU (and DIV/DIVU
// when MULDIV_ALU_DIV_EN is defined; otherwise DIV/DIVU act as undefined ops).
module muldiv_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned OPW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             res_zero, go_mul, go_div, md_signed, core_start;
  logic             core_done;
  logic [WIDTH-1:0] core_hi, core_lo;

  assign shamt      = in2[SHW-1:0];
  assign core_start = (state_q == IDLE) && in_valid && (go_mul || go_div);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .is_signed (md_signed),
    .is_div    (go_div),
    .a         (in1),
    .b         (in2),
    .done      (core_done),
    .hi        (core_hi),
    .lo        (core_lo)
  );

  // Opcode decode and single-cycle result
  always_comb begin
    res       = '0;
    res_zero  = 1'b0;
    go_mul    = 1'b0;
    go_div    = 1'b0;
    md_signed = 1'b0;
    case (op)
      OPW'(OP_ADD), OPW'(OP_ADDU): res = in1 + in2;
      OPW'(OP_SUB), OPW'(OP_SUBU): res = in1 - in2;
      OPW'(OP_AND):                res = in1 & in2;
      OPW'(OP_OR):                 res = in1 | in2;
      OPW'(OP_XOR):                res = in1 ^ in2;
      OPW'(OP_SLL), OPW'(OP_SLLV): res = in1 << shamt;
      OPW'(OP_SRL), OPW'(OP_SRLV): res = in1 >> shamt;
      OPW'(OP_SRA):                res = $unsigned($signed(in1) >>> shamt);
      OPW'(OP_SLT):                res = WIDTH'($signed(in1) < $signed(in2));
      OPW'(OP_SLTU):               res = WIDTH'(in1 < in2);
      OPW'(OP_JR):                 res = in1;
      OPW'(OP_LUI):                res = in2;
      OPW'(OP_MFHI):               res = hi_q;
      OPW'(OP_MFLO):               res = lo_q;
      OPW'(OP_BEQ):                res_zero = (in1 == in2);
      OPW'(OP_BNE):                res_zero = (in1 != in2);
      OPW'(OP_BGTZ):               res_zero = ~in1[WIDTH-1] && (in1 != '0);
      OPW'(OP_BLEZ):               res_zero = in1[WIDTH-1] || (in1 == '0);
      OPW'(OP_BGEZ):               res_zero = ~in1[WIDTH-1];
      OPW'(OP_BLTZ):               res_zero = in1[WIDTH-1];
      OPW'(OP_MULT):  begin go_mul = 1'b1; md_signed = 1'b1; end
      OPW'(OP_MULTU):       go_mul = 1'b1;
`ifdef MULDIV_ALU_DIV_EN
      OPW'(OP_DIV):   begin go_div = 1'b1; md_signed = 1'b1; end
      OPW'(OP_DIVU):        go_div = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (go_mul) begin
            state_d = MUL;
          end else if (go_div) begin
            state_d = DIV;
          end else begin
            out_d       = res;
            zero_d      = res_zero;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (core_done) begin
          state_d     = DONE;
          hi_d        = core_hi;
          lo_d        = core_lo;
          out_d       = core_lo;
          zero_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == MUL) || (state_d == DIV);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_muldiv_alu.sv
// Scoreboard bench for muldiv_alu: stimulus pushes expected results with their
// due cycle; a negedge monitor pops and compares on every out_valid strobe.
// DIV/DIVU expectations follow MULDIV_ALU_DIV_EN.
module tb_muldiv_alu;

  localparam logic [5:0] C_SLL = 6'b000000, C_SRL = 6'b000010, C_SRA = 6'b000011;
  localparam logic [5:0] C_MFHI = 6'b010000, C_MFLO = 6'b010010;
  localparam logic [5:0] C_MULT = 6'b011000, C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIV = 6'b011010, C_DIVU = 6'b011011;
  localparam logic [5:0] C_ADD = 6'b100000, C_SUB = 6'b100010;
  localparam logic [5:0] C_AND = 6'b100100, C_OR = 6'b100101, C_XOR = 6'b100110;
  localparam logic [5:0] C_SLT = 6'b101010, C_SLTU = 6'b101011;
  localparam logic [5:0] C_BEQ = 6'b110000, C_BNE = 6'b110001, C_BGTZ = 6'b110010;
  localparam logic [5:0] C_BLEZ = 6'b110011, C_BGEZ = 6'b110100, C_BLTZ = 6'b110101;
  localparam logic [5:0] C_UNDEF = 6'b111111;
  localparam int MUL_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, zero, busy;
  logic [5:0]  op;
  logic [31:0] in1, in2, out;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        zero;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  muldiv_alu #(.WIDTH(32), .OPW(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out(out), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Issue one request at a negedge; lat < 0 means no response is expected
  task automatic issue(input string nm, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic ez,
                       input int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_ready_wait"}, 64'(guard < 200), 64'd1);
    in_valid = 1'b1;
    op  = o;
    in1 = a;
    in2 = b;
    if (lat >= 0) exp_q.push_back('{nm, eo, ez, cyc + lat});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expectation in value and timing
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_strobe: got out=%0h at cycle %0d, required no strobe", out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk(mon_e.name, {31'd0, zero, out}, {31'd0, mon_e.zero, mon_e.out});
        chk({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out",       64'(out),       64'd0);
    chk("rst_zero",      64'(zero),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_busy",      64'(busy),      64'd0);

    // Single-cycle ops, issued back to back
    issue("add",      C_ADD,  32'h0FFFFFFF, 32'hFFFFFFFF, 32'h0FFFFFFE, 1'b0, 1);
    issue("add_wrap", C_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
    issue("sub",      C_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1);
    issue("and",      C_AND,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1);
    issue("or",       C_OR,   32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 1'b0, 1);
    issue("xor",      C_XOR,  32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 1'b0, 1);
    issue("sra",      C_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
    issue("srl",      C_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
    issue("sll_mask", C_SLL,  32'h00000001, 32'd36,       32'h00000010, 1'b0, 1);
    issue("slt",      C_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    issue("sltu",     C_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
    issue("beq",      C_BEQ,  32'd5,        32'd5,        32'd0,        1'b1, 1);
    issue("bne",      C_BNE,  32'd5,        32'd5,        32'd0,        1'b0, 1);
    issue("bgtz0",    C_BGTZ, 32'd0,        32'd9,        32'd0,        1'b0, 1);
    issue("blez0",    C_BLEZ, 32'd0,        32'd9,        32'd0,        1'b1, 1);
    issue("bgez_neg", C_BGEZ, 32'h80000000, 32'd0,        32'd0,        1'b0, 1);
    issue("bltz_neg", C_BLTZ, 32'h80000000, 32'd0,        32'd0,        1'b1, 1);
    issue("undef",    C_UNDEF,32'h12345678, 32'h9ABCDEF0, 32'd0,        1'b0, 1);

    // Signed multiply: busy for exactly 32 cycles, result after 33
    issue("mult", C_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, MUL_LAT);
    chk("mult_in_ready_low", 64'(in_ready), 64'd0);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mult_busy_cycles", 64'(n), 64'd32);
    issue("mult_mfhi", C_MFHI, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
    issue("mult_mflo", C_MFLO, 32'd0, 32'd0, 32'hFFFFFFEB, 1'b0, 1);

    issue("multu",      C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, MUL_LAT);
    issue("multu_mfhi", C_MFHI,  32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1);

`ifdef MULDIV_ALU_DIV_EN
    issue("div",       C_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, MUL_LAT);
    issue("div_mfhi",  C_MFHI, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
    issue("divu",      C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, MUL_LAT);
    issue("divu_mfhi", C_MFHI, 32'd0, 32'd0, 32'd2, 1'b0, 1);
    issue("div0",      C_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, MUL_LAT);
    issue("div0_mfhi", C_MFHI, 32'd0, 32'd0, 32'd5, 1'b0, 1);
    issue("div0_mflo", C_MFLO, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
`else
    issue("div_undef",  C_DIV,  32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 1);
    issue("divu_undef", C_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 1);
    issue("undef_mflo", C_MFLO, 32'd0, 32'd0, 32'h00000001, 1'b0, 1);
    issue("undef_mfhi", C_MFHI, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1);
`endif

    // Reset in the middle of MULTU aborts it and clears HI/LO
    issue("multu_abort", C_MULTU, 32'h00001234, 32'h00005678, 32'd0, 1'b0, -1);
    repeat (8) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy",     64'(busy),     64'd0);
    chk("abort_out",      64'(out),      64'd0);
    repeat (40) @(negedge clk);
    issue("abort_mflo", C_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 1);
    issue("abort_mfhi", C_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
